ps2_transmit: RTL

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA host to the keyboard over the open-drain ps2c/ps2d lines and reports the device acknowledge. It shares both lines with ps2_receive. Its tx_idle output drives the receiver's r_enable, so the receiver ignores clocks the device generates for host frames.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_transmit_if.sv | 14 +
 rtl/ps2_clk_filter.sv | 33 +++
 rtl/ps2_transmit.sv | 137 +++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame width, default timing constants.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RTS   = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } tx_state_t;

  localparam int FRAME_BITS         = 9;
  localparam int INHIBIT_CYCLES_DEF = 10000;
  localparam int TIMEOUT_CYCLES_DEF = 2000000;

  // Data byte plus odd parity, LSB first on the wire.
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] b);
    return {~^b, b};
  endfunction

endpackage

// File: rtl/ps2_transmit_if.sv
// Host-side command handshake of the PS/2 transmitter: start strobe, byte, status and result ticks.
interface ps2_transmit_if;
  logic       wr_ps2;
  logic [7:0] din;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       ack_err_tick;
  logic       timeout_tick;

  modport master (output wr_ps2, din,
                  input  tx_idle, tx_done_tick, ack_err_tick, timeout_tick);
  modport slave  (input  wr_ps2, din,
                  output tx_idle, tx_done_tick, ack_err_tick, timeout_tick);
endinterface

// File: rtl/ps2_clk_filter.sv
// 8-sample debounce of the raw PS/2 clock; filtered level plus a one-cycle fall strobe
// (8-9 clk after the line settles low). Shared with ps2_receive.
module ps2_clk_filter (
  input  logic clk,
  input  logic reset,
  input  logic ps2c_in,
  output logic filtered,
  output logic fall
);

  logic [7:0] sr;
  logic       filt_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr       <= 8'h00;
      filtered <= 1'b0;
    end else begin
      sr       <= {ps2c_in, sr[7:1]};
      filtered <= filt_next;
    end
  end

  // Level only moves on a full window of agreeing samples; partial windows hold it.
  always_comb begin
    filt_next = filtered;
    if (sr == 8'hFF)      filt_next = 1'b1;
    else if (sr == 8'h00) filt_next = 1'b0;
  end

  assign fall = filtered & ~filt_next;

endmodule

// File: rtl/ps2_transmit.sv
// Host-to-device PS/2 command transmitter with device-ACK check; ticks are Mealy in the final-edge cycle.
// Optional watchdog on device clock edges when PS2_TX_TIMEOUT_EN is defined.
module ps2_transmit
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ps2c_in,
  input  logic                 ps2d_in,
  ps2_transmit_if.slave        host,
  output logic                 ps2c_oe,
  output logic                 ps2d_oe
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

  tx_state_t             state, state_next;
  logic [INH_W-1:0]      inh_cnt, inh_next;
  logic [3:0]            n_reg, n_next;
  logic [FRAME_BITS-1:0] frame_reg, frame_next;
  logic                  fall, filt_level_unused;
  logic                  idle_c, done_c, err_c, to_c;
  logic                  active;

  ps2_clk_filter u_filter (
    .clk      (clk),
    .reset    (reset),
    .ps2c_in  (ps2c_in),
    .filtered (filt_level_unused),
    .fall     (fall)
  );

  assign active = (state == START) || (state == DATA) || (state == STOP);

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_expire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              wd_cnt <= '0;
    else if (state == RTS && inh_cnt == '0) wd_cnt <= WD_W'(TIMEOUT_CYCLES - 1);
    else if (active && fall)                wd_cnt <= WD_W'(TIMEOUT_CYCLES - 1);
    else if (active && wd_cnt != '0)        wd_cnt <= wd_cnt - WD_W'(1);
  end

  // A real edge in the same cycle wins over the watchdog.
  assign wd_expire = active && (wd_cnt == '0) && !fall;
`else
  logic wd_expire, timeout_cfg_unused;
  assign wd_expire          = 1'b0;
  assign timeout_cfg_unused = (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      inh_cnt   <= '0;
      n_reg     <= '0;
      frame_reg <= '0;
    end else begin
      state     <= state_next;
      inh_cnt   <= inh_next;
      n_reg     <= n_next;
      frame_reg <= frame_next;
    end
  end

  always_comb begin
    state_next = state;
    inh_next   = inh_cnt;
    n_next     = n_reg;
    frame_next = frame_reg;
    ps2c_oe    = 1'b0;
    ps2d_oe    = 1'b0;
    idle_c     = 1'b0;
    done_c     = 1'b0;
    err_c      = 1'b0;
    to_c       = 1'b0;
    case (state)
      IDLE: begin
        idle_c = 1'b1;
        if (host.wr_ps2) begin
          frame_next = make_frame(host.din);
          inh_next   = INH_W'(INHIBIT_CYCLES - 1);
          state_next = RTS;
        end
      end
      RTS: begin
        ps2c_oe = 1'b1;
        if (inh_cnt == '0) state_next = START;
        else               inh_next   = inh_cnt - INH_W'(1);
      end
      START: begin
        ps2d_oe = 1'b1;
        if (fall) begin
          n_next     = 4'd8;
          state_next = DATA;
        end
      end
      DATA: begin
        ps2d_oe = ~frame_reg[0];
        if (fall) begin
          if (n_reg == 4'd0) begin
            state_next = STOP;
          end else begin
            frame_next = frame_reg >> 1;
            n_next     = n_reg - 4'd1;
          end
        end
      end
      STOP: begin
        if (fall) begin
          done_c     = ~ps2d_in;
          err_c      = ps2d_in;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (wd_expire) begin
      ps2c_oe    = 1'b0;
      ps2d_oe    = 1'b0;
      to_c       = 1'b1;
      state_next = IDLE;
    end
  end

  assign host.tx_idle      = idle_c;
  assign host.tx_done_tick = done_c;
  assign host.ack_err_tick = err_c;
  assign host.timeout_tick = to_c;

endmodule
